// File: rtl/fix_adder_arbiter.sv
// fix_adder_arbiter
//   Round-robin front end for one shared sign-magnitude fixed-point adder.
//   Grants one of R requesting lanes, latches that lane's operands and runs
//   the adder poke/peek handshake. The sum goes back to the winning lane as
//   a one-cycle response. A hung adder ends the wait after TIMEOUT cycles.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   req_valid[R]         per-lane request
//   req_a/req_b[R*N]     lane i operands at [i*N +: N]
//   req_ready[R]         one-hot grant pulse; operands sampled this cycle
//   rsp_valid[R]         one-hot response pulse
//   rsp_sum/err/id       response payload, valid with rsp_valid
//   add_a/add_b          operands to the shared adder
//   add_poke             adder start/hold
//   add_peek, add_sum    adder result-valid and result
//   busy                 controller not idle
//   timeout_err          sticky timeout flag, cleared only by rst
module fix_adder_arbiter #(
    parameter int unsigned N       = 16,
    parameter int unsigned Q       = 13,
    parameter int unsigned R       = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned IDW     = $clog2(R)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [R-1:0]     req_valid,
    input  logic [R*N-1:0]   req_a,
    input  logic [R*N-1:0]   req_b,
    output logic [R-1:0]     req_ready,
    output logic [R-1:0]     rsp_valid,
    output logic [N-1:0]     rsp_sum,
    output logic             rsp_err,
    output logic [IDW-1:0]   rsp_id,
    output logic [N-1:0]     add_a,
    output logic [N-1:0]     add_b,
    output logic             add_poke,
    input  logic             add_peek,
    input  logic [N-1:0]     add_sum,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_RELEASE} state_t;

    localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(R - 1);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [N-1:0]   opa_q, opa_d;
    logic [N-1:0]   opb_q, opb_d;
    logic [N-1:0]   sum_q, sum_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           terr_q, terr_d;

    logic           any_req;
    logic [IDW-1:0] pick;
    int unsigned    arb_idx;
    logic [N-1:0]   sel_a, sel_b;
    logic           grant;
    logic           neg_zero;
    logic [N-1:0]   sum_canon;
    logic [IDW-1:0] next_ptr;

    // First requester at or after ptr_q, wrapping modulo R.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        arb_idx = 0;
        for (int unsigned off = 0; off < R; off++) begin
            arb_idx = (32'(ptr_q) + off) % R;
            if (!any_req && req_valid[IDW'(arb_idx)]) begin
                any_req = 1'b1;
                pick    = IDW'(arb_idx);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (pick == IDW'(i)) begin
                sel_a = req_a[i*N +: N];
                sel_b = req_b[i*N +: N];
            end
        end
    end

    // A held peek means the adder still owns its last result; no new grant.
    assign grant = (state_q == S_IDLE) && !add_peek && any_req;

    // Negative zero: sign set with empty integer and fraction magnitude fields.
    assign neg_zero  = add_sum[N-1] && (add_sum[N-2:Q] == '0) && (add_sum[Q-1:0] == '0);
    assign sum_canon = neg_zero ? '0 : add_sum;
    assign next_ptr  = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        terr_d  = terr_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    opa_d   = sel_a;
                    opb_d   = sel_b;
                    gid_d   = pick;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (add_peek) begin
                    sum_d   = sum_canon;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    sum_d   = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (err_q) begin
                    terr_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!add_peek) begin
                    ptr_d   = next_ptr;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d  = 1'b1;
                    ptr_d   = next_ptr;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The grant is combinational off req_valid; mask it while reset holds state in IDLE.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_sum   = '0;
        rsp_err   = 1'b0;
        rsp_id    = '0;
        busy      = (state_q != S_IDLE);
        add_poke  = (state_q == S_ISSUE);
        for (int unsigned i = 0; i < R; i++) begin
            req_ready[i] = grant && !rst && (pick == IDW'(i));
        end
        if (state_q == S_RESP) begin
            for (int unsigned i = 0; i < R; i++) begin
                rsp_valid[i] = (gid_q == IDW'(i));
            end
            rsp_sum = sum_q;
            rsp_err = err_q;
            rsp_id  = gid_q;
        end
    end

    assign add_a       = opa_q;
    assign add_b       = opb_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_fix_adder_arbiter.sv
module tb_fix_adder_arbiter;

    localparam int N   = 16;
    localparam int Q   = 13;
    localparam int R   = 4;
    localparam int TO  = 64;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [R-1:0]    req_valid;
    logic [R*N-1:0]  req_a, req_b;
    logic [R-1:0]    req_ready, rsp_valid;
    logic [N-1:0]    rsp_sum;
    logic            rsp_err;
    logic [IDW-1:0]  rsp_id;
    logic [N-1:0]    add_a, add_b, add_sum;
    logic            add_poke, add_peek;
    logic            busy, timeout_err;

    logic [N-1:0]    la [R];
    logic [N-1:0]    lb [R];

    // adder environment model
    logic            model_peek = 1'b0;
    logic            force_peek = 1'b0;
    logic [N-1:0]    model_sum  = '0;
    int unsigned     lat        = 1;
    bit              adder_hang = 1'b0;
    bit              negzero    = 1'b0;
    int              acnt       = 0;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int           id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] sum;
        logic         err;
        int           lat;
        int           gcyc;
    } exp_t;

    exp_t         sb[$];
    int           grant_log[$];
    int           ref_ptr   = 0;
    logic [N-1:0] last_sum  = '0;
    logic         last_err  = 1'b0;
    int           last_id   = 0;
    int           rsp_count = 0;
    exp_t         mon_e;
    int           mon_g;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign add_peek = model_peek | force_peek;
    assign add_sum  = model_sum;

    always_comb begin
        for (int i = 0; i < R; i++) begin
            req_a[i*N +: N] = la[i];
            req_b[i*N +: N] = lb[i];
        end
    end

    fix_adder_arbiter #(
        .N(N), .Q(Q), .R(R), .TIMEOUT(TO), .IDW(IDW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum),
        .rsp_err(rsp_err), .rsp_id(rsp_id),
        .add_a(add_a), .add_b(add_b), .add_poke(add_poke),
        .add_peek(add_peek), .add_sum(add_sum),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Signed-value addition of two sign-magnitude numbers.
    function automatic logic [N-1:0] sm_ref(input logic [N-1:0] a, input logic [N-1:0] b);
        int va, vb, s;
        logic [N-1:0] r;
        va = int'(a[N-2:0]);
        if (a[N-1]) va = -va;
        vb = int'(b[N-2:0]);
        if (b[N-1]) vb = -vb;
        s = va + vb;
        r = '0;
        if (s < 0) begin
            s = -s;
            r[N-1] = 1'b1;
        end
        r[N-2:0] = s[N-2:0];
        return r;
    endfunction

    function automatic int ref_pick(input logic [R-1:0] v, input int p);
        for (int k = 0; k < R; k++) begin
            if (v[(p + k) % R]) return (p + k) % R;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] rnd_op();
        logic [N-1:0] r;
        r = N'($urandom_range(0, (1 << (N - 2)) - 1));
        if ($urandom_range(0, 1) == 1) r[N-1] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Adder: raises peek lat cycles after poke, drops it once poke goes low.
    always @(posedge clk) begin
        if (rst) begin
            model_peek <= 1'b0;
            acnt       <= 0;
        end else if (add_poke) begin
            if (!adder_hang && !model_peek && (acnt + 1 >= int'(lat))) begin
                logic [N-1:0] s;
                s = sm_ref(add_a, add_b);
                if (negzero && s == '0) s = {1'b1, {(N-1){1'b0}}};
                model_peek <= 1'b1;
                model_sum  <= s;
            end
            acnt <= acnt + 1;
        end else begin
            model_peek <= 1'b0;
            acnt       <= 0;
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                ref_ptr = 0;
            end else begin
                if (req_ready != '0) begin
                    mon_g = ref_pick(req_valid, ref_ptr);
                    chk("grant_onehot", $countones(req_ready), 1);
                    chk("grant_lane", 32'(req_ready), 32'(1 << mon_g));
                    mon_e.id   = mon_g;
                    mon_e.a    = la[mon_g];
                    mon_e.b    = lb[mon_g];
                    mon_e.err  = adder_hang;
                    mon_e.sum  = adder_hang ? '0 : sm_ref(la[mon_g], lb[mon_g]);
                    mon_e.lat  = adder_hang ? TO + 1 : int'(lat) + 2;
                    mon_e.gcyc = cyc;
                    sb.push_back(mon_e);
                    grant_log.push_back(mon_g);
                end
                if (add_poke) begin
                    chk("poke_pending", sb.size(), 1);
                    if (sb.size() > 0) begin
                        chk("add_a", add_a, sb[0].a);
                        chk("add_b", add_b, sb[0].b);
                    end
                end
                if (rsp_valid != '0) begin
                    chk("rsp_pending", sb.size(), 1);
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        chk("rsp_valid", 32'(rsp_valid), 32'(1 << mon_e.id));
                        chk("rsp_id", 32'(rsp_id), mon_e.id);
                        chk("rsp_sum", rsp_sum, mon_e.sum);
                        chk("rsp_err", rsp_err, mon_e.err);
                        chk("rsp_latency", cyc - mon_e.gcyc, mon_e.lat);
                        ref_ptr   = (mon_e.id + 1) % R;
                        last_sum  = rsp_sum;
                        last_err  = rsp_err;
                        last_id   = int'(rsp_id);
                        rsp_count++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_grants(input int k, input bit drop);
        int got = 0;
        int n = 0;
        logic [R-1:0] rr;
        while (got < k && n < 600) begin
            @(negedge clk);
            #1;
            n++;
            rr = req_ready;
            if (rr != '0) begin
                got++;
                if (drop || got == k) begin
                    tick();
                    if (drop) req_valid = req_valid & ~rr;
                    else      req_valid = '0;
                end
            end
        end
        chk("grants_seen", got, k);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || sb.size() != 0) && n < budget);
        chk("idle_reached", (busy ? 1 : 0) + sb.size(), 0);
    endtask

    task automatic issue_one(input int lane, input logic [N-1:0] a, input logic [N-1:0] b);
        tick();
        la[lane] = a;
        lb[lane] = b;
        req_valid[lane] = 1'b1;
        run_grants(1, 1'b1);
        wait_idle(200);
    endtask

    task automatic chk_order(input string nm, input int base, input int e0, input int e1);
        chk(nm, (base < grant_log.size()) ? grant_log[base] : -1, e0);
        chk(nm, (base + 1 < grant_log.size()) ? grant_log[base + 1] : -1, e1);
    endtask

    initial begin
        int gl, n, rc;
        int exp5[5] = '{0, 1, 2, 3, 0};
        logic [R-1:0] mask;

        for (int i = 0; i < R; i++) begin
            la[i] = rnd_op();
            lb[i] = rnd_op();
        end
        req_valid = '1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_poke", add_poke, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        tick();
        rst = 1'b0;

        // all lanes held from reset
        gl = grant_log.size();
        run_grants(5, 1'b0);
        wait_idle(200);
        for (int k = 0; k < 5; k++) begin
            chk("fair_order", (gl + k < grant_log.size()) ? grant_log[gl + k] : -1, exp5[k]);
        end

        // lanes 0 and 2 with pointer at 1
        tick();
        req_valid = 4'b0101;
        gl = grant_log.size();
        run_grants(2, 1'b1);
        wait_idle(200);
        chk_order("fair_ptr1", gl, 2, 0);

        // single request, 1.0 + 0.5
        issue_one(0, 16'h2000, 16'h1000);
        chk("single_sum", last_sum, 16'h3000);
        chk("single_err", last_err, 0);
        chk("single_id", last_id, 0);

        // mixed signs; adder reports negative zero
        negzero = 1'b1;
        issue_one(3, 16'h2000, 16'hA000);
        chk("mixed_zero", last_sum, 16'h0000);
        issue_one(3, 16'h0800, 16'h9000);
        chk("mixed_neg", last_sum, 16'h8800);
        negzero = 1'b0;

        // random contention rounds
        for (int r = 0; r < 25; r++) begin
            lat     = $urandom_range(1, 4);
            negzero = ($urandom_range(0, 1) == 1);
            mask    = R'($urandom_range(1, (1 << R) - 1));
            for (int i = 0; i < R; i++) begin
                if (mask[i]) begin
                    la[i] = rnd_op();
                    if ($urandom_range(0, 3) == 0) lb[i] = la[i] ^ {1'b1, {(N-1){1'b0}}};
                    else                           lb[i] = rnd_op();
                end
            end
            tick();
            req_valid = mask;
            run_grants($countones(mask), 1'b1);
            wait_idle(300);
        end
        lat     = 1;
        negzero = 1'b0;

        // peek stuck high while idle
        tick();
        force_peek = 1'b1;
        la[1] = 16'h0400;
        lb[1] = 16'h0400;
        req_valid[1] = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (req_ready != '0) n++;
        end
        chk("stuck_no_grant", n, 0);
        tick();
        force_peek = 1'b0;
        @(negedge clk);
        #1;
        chk("stuck_grant_next", 32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        wait_idle(200);
        chk("stuck_sum", last_sum, 16'h0800);

        // adder never answers
        adder_hang = 1'b1;
        issue_one(2, 16'h1234, 16'h0111);
        chk("to_err", last_err, 1);
        chk("to_sum", last_sum, 0);
        chk("to_sticky", timeout_err, 1);
        adder_hang = 1'b0;
        issue_one(0, 16'h0100, 16'h0100);
        chk("to_sticky_after_ok", timeout_err, 1);
        chk("to_ok_err", last_err, 0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("to_cleared", timeout_err, 0);
        tick();
        rst = 1'b0;

        // lane 2 completes, leaving the pointer at 3
        issue_one(2, 16'h0100, 16'h0200);
        chk("ptr_setup_sum", last_sum, 16'h0300);

        // reset during ISSUE
        adder_hang = 1'b1;
        tick();
        la[2] = 16'h0010;
        lb[2] = 16'h0020;
        req_valid[2] = 1'b1;
        run_grants(1, 1'b1);
        @(negedge clk);
        #1;
        chk("mid_poke_before", add_poke, 1);
        rc = rsp_count;
        req_valid = 4'b1010;
        rst = 1'b1;
        #1;
        chk("mid_poke", add_poke, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_req_ready", 32'(req_ready), 0);
        adder_hang = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        gl = grant_log.size();
        run_grants(2, 1'b1);
        wait_idle(200);
        chk_order("post_rst_order", gl, 1, 3);
        chk("no_stale_rsp", rsp_count - rc, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fix_adder_arbiter.md
Name: fix_adder_arbiter

Overview:
- Shares one sign-magnitude fixed-point adder (N-bit, Q fractional bits, MSB = sign) between R requesters, e.g. the neuron accumulation lanes.
- Arbitrates round-robin and latches the winner's operands.
- Drives the adder's poke/peek handshake, captures the sum and returns it to the winning requester.
- Sits between the per-lane MAC sequencers and the single shared adder instance.

Parameters:
- N, 16, operand/result width (sign-magnitude, bit N-1 = sign).
- Q, 13, fractional bits. The arbiter does not use Q arithmetically; it is passed for consistency.
- R, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles to wait on add_peek in ISSUE or RELEASE.
- IDW, $clog2(R), requester id width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  R  per-lane request.
- req_a  in  R*N  lane i operand a at [i*N +: N].
- req_b  in  R*N  lane i operand b at [i*N +: N].
- req_ready  out  R  one-hot, one-cycle grant pulse; operands are sampled this cycle.
- rsp_valid  out  R  one-hot, one-cycle response pulse.
- rsp_sum  out  N  result, valid while any rsp_valid bit is high.
- rsp_err  out  1  high with rsp_valid when the operation timed out.
- rsp_id  out  IDW  id of the responding lane.
- add_a  out  N  operand a to the shared adder.
- add_b  out  N  operand b to the shared adder.
- add_poke  out  1  adder start/hold.
- add_peek  in  1  adder result-valid.
- add_sum  in  N  adder result.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on any timeout, cleared only by rst.

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; round-robin pointer 0; operand registers 0; timeout counter 0.
- States: IDLE, ISSUE, RESP, RELEASE.
- IDLE:
  - If add_peek=1, stay in IDLE (the adder is not yet released).
  - Otherwise grant the lowest index g >= ptr (wrapping modulo R) with req_valid[g]=1.
  - Grant cycle: req_ready[g]=1, latch req_a/req_b slice g into the operand registers, record g, go to ISSUE.
  - No valid requests: stay in IDLE, all outputs idle.
- ISSUE:
  - add_poke=1; add_a/add_b driven from the latched registers and held stable for the whole state.
  - Timeout counter increments each cycle.
  - On add_peek=1: capture add_sum, clear the counter, go to RESP.
  - On counter reaching TIMEOUT-1 without add_peek: set the capture register to 0, set the err flag, go to RESP.
- RESP, one cycle:
  - add_poke=0.
  - rsp_valid[g]=1, rsp_id=g, rsp_sum=captured value, rsp_err=err flag.
  - Set timeout_err if the err flag is set.
  - Go to RELEASE.
- RELEASE:
  - add_poke=0; wait for add_peek=0, with the timeout counter running.
  - On add_peek=0: set ptr=(g+1) mod R, clear err, go to IDLE.
  - On timeout: set timeout_err, set ptr=(g+1) mod R, go to IDLE. No second response is issued.
- Canonical zero: a captured add_sum equal to a sign bit only (1 followed by N-1 zeros, 0x8000 at N=16) is stored as all-zeros. All other values pass through unmodified.
- Latency:
  - Grant to rsp_valid = adder latency + 2 cycles (ISSUE capture edge, then RESP).
  - Minimum grant-to-grant interval is 4 cycles.
- req_valid may drop after the grant without effect. A lane re-requesting immediately after its response loses priority to the other lanes.
- Simultaneous requests: exactly one grant per arbitration; no lane waits more than R-1 other grants.
- rst asserted mid-operation: outputs return to 0 asynchronously and the in-flight operation is discarded with no response.

Test Plan:
- Single request: lane 0 with a=0x2000, b=0x1000 (1.0 + 0.5), adder model with 1-cycle latency -> req_ready=0001 for one cycle; rsp_valid=0001 with rsp_sum=0x3000, rsp_err=0, rsp_id=0, 3 cycles after grant.
- Fairness: all 4 lanes held valid from reset -> grant order 0,1,2,3,0. Then only lanes 0 and 2 valid with ptr=1 -> lane 2 is granted before lane 0.
- Mixed signs: lane 3 with a=0x2000, b=0xA000 (1.0 + -1.0); adder returns 0x8000 -> rsp_sum=0x0000. Second case a=0x0800, b=0x9000 -> rsp_sum=0x8800.
- Timeout: adder model never raises peek -> after 64 ISSUE cycles rsp_valid pulses with rsp_sum=0, rsp_err=1; timeout_err stays high until rst.
- Stuck peek: add_peek held high in IDLE with lane 1 valid -> no req_ready until add_peek=0, then grant on the next cycle.
- Reset mid-ISSUE: assert rst while add_poke=1 -> add_poke, busy and all rsp_valid/req_ready bits go to 0 immediately. After release, ptr=0 and no stale response appears.
